// File: rtl/debounce_edge.sv
// Debounce and edge-detection stage fed by a bit synchronizer.
// Optional glitch counter: define DEBOUNCE_EDGE_GLITCH_CNT_EN.
module debounce_edge #(
    parameter int unsigned DebounceCycles = 16,
    parameter int unsigned CntWidth       = 8,
    parameter int unsigned GlitchCntWidth = 8,
    parameter bit          ResetValue     = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      serial_i,
    input  logic                      clr_i,
    output logic                      level_o,
    output logic                      rise_o,
    output logic                      fall_o,
    output logic [GlitchCntWidth-1:0] glitch_cnt_o
);

    // Illegal filter lengths stop elaboration.
    if (DebounceCycles < 2 ||
        DebounceCycles > (2 ** CntWidth) - 1) begin : g_bad_cycles
        $fatal(1, "debounce_edge: DebounceCycles out of range");
    end

    typedef enum logic [1:0] {
        STABLE_LO,
        CHK_HI,
        STABLE_HI,
        CHK_LO
    } state_e;

    localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceCycles - 1);
    localparam state_e StateRst = ResetValue ? STABLE_HI : STABLE_LO;

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                level_q, level_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic                glitch_evt;

    // State, counter and registered outputs; reset discards any candidate.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StateRst;
            cnt_q   <= '0;
            level_q <= ResetValue;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state logic: track a candidate level until it has held long enough.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        level_d    = level_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        glitch_evt = 1'b0;
        unique case (state_q)
            STABLE_LO: begin
                if (serial_i) begin
                    state_d = CHK_HI;
                    cnt_d   = CntWidth'(1);
                end
            end
            CHK_HI: begin
                if (serial_i) begin
                    if (cnt_q == CntLast) begin
                        state_d = STABLE_HI;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d    = STABLE_LO;
                    glitch_evt = 1'b1;
                end
            end
            STABLE_HI: begin
                if (!serial_i) begin
                    state_d = CHK_LO;
                    cnt_d   = CntWidth'(1);
                end
            end
            CHK_LO: begin
                if (!serial_i) begin
                    if (cnt_q == CntLast) begin
                        state_d = STABLE_LO;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d    = STABLE_HI;
                    glitch_evt = 1'b1;
                end
            end
            default: begin
                state_d = StateRst;
                level_d = ResetValue;
            end
        endcase
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

`ifdef DEBOUNCE_EDGE_GLITCH_CNT_EN
    logic [GlitchCntWidth-1:0] glitch_q, glitch_d;

    // Saturating glitch count; a clear wins over a same-cycle glitch.
    always_comb begin
        glitch_d = glitch_q;
        if (clr_i) begin
            glitch_d = '0;
        end else if (glitch_evt && (glitch_q != '1)) begin
            glitch_d = glitch_q + 1'b1;
        end
    end

    // Glitch counter register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt_o = glitch_q;
`else
    logic unused_glitch;
    assign unused_glitch = clr_i ^ glitch_evt;
    assign glitch_cnt_o  = '0;
`endif

endmodule
